pio_tx_fifo: RTL and testbench

Per-state-machine TX FIFO for the PIO block. It sits between the bus-side TXF register write path in pio_regs and the OSR/state_machine PULL path.
- Bus writes push 32-bit words; the state machine pulls words into the OSR.
- Supports blocking and non-blocking PULL semantics.
- Reports FIFO level and status flags for FSTAT/FLEVEL.
- Keeps sticky TXOVER/TXSTALL debug bits for FDEBUG.

---
 rtl/pio_pkg.sv | 15 +
 rtl/pio_fifo_mem.sv | 27 ++
 rtl/pio_tx_fifo.sv | 151 +++++++++++++++
 tb/tb_pio_tx_fifo.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared PIO constants and FSTAT/FDEBUG per-state-machine field layout.
package pio_pkg;

    localparam int PIO_FIFO_DEPTH = 4;
    localparam int PIO_DW         = 32;
    localparam int PIO_LVL_W      = 5;

    typedef struct packed {
        logic txfull;
        logic txempty;
        logic txover;
        logic txstall;
    } pio_fstat_t;

endpackage

// File: rtl/pio_fifo_mem.sv
// Register-file storage for the TX FIFO: one write port, asynchronous read.
module pio_fifo_mem
    import pio_pkg::*;
#(
    parameter int DEPTH = PIO_FIFO_DEPTH,
    parameter int DW    = PIO_DW,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pio_tx_fifo.sv
// Per-SM PIO TX FIFO with blocking/non-blocking pull and sticky debug bits.
// Define PIO_TX_JOIN_EN to add fjoin_tx (borrow RX storage, 2*DEPTH entries).
module pio_tx_fifo
    import pio_pkg::*;
#(
    parameter int DEPTH = PIO_FIFO_DEPTH,
    parameter int DW    = PIO_DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 push,
    input  logic [DW-1:0]        push_data,
    input  logic                 pull_req,
    input  logic                 pull_block,
    input  logic [DW-1:0]        x_reg,
`ifdef PIO_TX_JOIN_EN
    input  logic                 fjoin_tx,
`endif
    output logic                 pull_ack,
    output logic [DW-1:0]        pull_data,
    output logic                 stall,
    output logic                 full,
    output logic                 empty,
    output logic [PIO_LVL_W-1:0] level,
    output logic                 txover,
    output logic                 txstall,
    input  logic                 clr_txover,
    input  logic                 clr_txstall
);

`ifdef PIO_TX_JOIN_EN
    localparam int SDEPTH = 2 * DEPTH;
`else
    localparam int SDEPTH = DEPTH;
`endif
    localparam int AW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
    localparam logic [PIO_LVL_W-1:0] CAP_N = PIO_LVL_W'(DEPTH);

    logic [AW-1:0]        r_rd_ptr;
    logic [AW-1:0]        r_wr_ptr;
    logic [PIO_LVL_W-1:0] r_level;
    logic                 r_txover;
    logic                 r_txstall;

    logic [PIO_LVL_W-1:0] w_cap;
    logic [DW-1:0]        w_head;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push_ok;
    logic                 w_drop;
    logic                 w_stall;
    logic                 w_flush;

    // A change of join mode reshapes storage, so it empties the FIFO.
`ifdef PIO_TX_JOIN_EN
    localparam logic [PIO_LVL_W-1:0] CAP_J = PIO_LVL_W'(2 * DEPTH);
    logic r_fjoin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fjoin <= 1'b0;
        end else begin
            r_fjoin <= fjoin_tx;
        end
    end

    assign w_cap   = r_fjoin ? CAP_J : CAP_N;
    assign w_flush = flush | (fjoin_tx != r_fjoin);
`else
    assign w_cap   = CAP_N;
    assign w_flush = flush;
`endif

    function automatic logic [AW-1:0] ptr_inc(
        input logic [AW-1:0]        p,
        input logic [PIO_LVL_W-1:0] cap
    );
        return (PIO_LVL_W'(p) == cap - 1'b1) ? '0 : p + AW'(1);
    endfunction

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == w_cap);
    assign w_pop     = pull_req & ~w_empty;
    assign w_push_ok = push & (~w_full | w_pop);
    assign w_drop    = push & w_full & ~w_pop;
    assign w_stall   = pull_req & pull_block & w_empty;

    pio_fifo_mem #(
        .DEPTH (SDEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push_ok & ~w_flush),
        .i_waddr (r_wr_ptr),
        .i_wdata (push_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr, w_cap);
            end
            if (w_push_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr, w_cap);
            end
            if (w_push_ok && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push_ok) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Set wins over a same-cycle W1C clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_txover  <= 1'b0;
            r_txstall <= 1'b0;
        end else begin
            if (w_drop) begin
                r_txover <= 1'b1;
            end else if (clr_txover) begin
                r_txover <= 1'b0;
            end
            if (w_stall) begin
                r_txstall <= 1'b1;
            end else if (clr_txstall) begin
                r_txstall <= 1'b0;
            end
        end
    end

    assign pull_ack  = pull_req & (~w_empty | ~pull_block);
    assign pull_data = w_empty ? x_reg : w_head;
    assign stall     = w_stall;
    assign full      = w_full;
    assign empty     = w_empty;
    assign level     = r_level;
    assign txover    = r_txover;
    assign txstall   = r_txstall;

endmodule

// File: tb/tb_pio_tx_fifo.sv
// Self-checking bench for pio_tx_fifo against a queue-based reference model.
module tb_pio_tx_fifo;

    localparam int D  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pull_req;
    logic          pull_block;
    logic [DW-1:0] x_reg;
    logic          pull_ack;
    logic [DW-1:0] pull_data;
    logic          stall;
    logic          full;
    logic          empty;
    logic [4:0]    level;
    logic          txover;
    logic          txstall;
    logic          clr_txover;
    logic          clr_txstall;
    logic          fjoin_tx;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic          m_ov;
    logic          m_st;
    logic          m_fj;

    always #5 clk = ~clk;

    pio_tx_fifo #(.DEPTH(D), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .push        (push),
        .push_data   (push_data),
        .pull_req    (pull_req),
        .pull_block  (pull_block),
        .x_reg       (x_reg),
`ifdef PIO_TX_JOIN_EN
        .fjoin_tx    (fjoin_tx),
`endif
        .pull_ack    (pull_ack),
        .pull_data   (pull_data),
        .stall       (stall),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .txover      (txover),
        .txstall     (txstall),
        .clr_txover  (clr_txover),
        .clr_txstall (clr_txstall)
    );

    function automatic int cap();
`ifdef PIO_TX_JOIN_EN
        return m_fj ? 2 * D : D;
`else
        return D;
`endif
    endfunction

    task automatic drive(input logic p, input logic [DW-1:0] d,
                         input logic pr, input logic pb,
                         input logic fl, input logic co, input logic cs);
        push        = p;
        push_data   = d;
        pull_req    = pr;
        pull_block  = pb;
        flush       = fl;
        clr_txover  = co;
        clr_txstall = cs;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock; the model applies the FIFO rules to the same inputs.
    task automatic tick();
        bit is_empty = (q.size() == 0);
        bit is_full  = (q.size() == cap());
        bit pop      = pull_req && !is_empty;
        if (pull_req && pull_block && is_empty) m_st = 1'b1;
        else if (clr_txstall) m_st = 1'b0;
        if (push && is_full && !pop) m_ov = 1'b1;
        else if (clr_txover) m_ov = 1'b0;
        if (pop) void'(q.pop_front());
        if (push && (!is_full || pop)) q.push_back(push_data);
        if (flush) q.delete();
`ifdef PIO_TX_JOIN_EN
        if (fjoin_tx != m_fj) begin
            q.delete();
            m_fj = fjoin_tx;
        end
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        fjoin_tx = 1'b0;
        x_reg    = 32'h0BAD_F00D;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_ov = 1'b0;
        m_st = 1'b0;
        m_fj = 1'b0;
        #1;
        checks++;
        if ({level, empty, full, txover, txstall} !== {5'd0, 4'b1000}) begin
            errors++;
            $display("FAIL reset_flags got lvl=%0d e=%b f=%b ov=%b st=%b want 0 1 0 0 0",
                     level, empty, full, txover, txstall);
        end
        checks++;
        if ({pull_ack, stall} !== 2'b00 || pull_data !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL reset_pull got ack=%b stall=%b data=%h want 0 0 0badf00d",
                     pull_ack, stall, pull_data);
        end
        @(negedge clk);
    endtask

    task automatic test_stall_sticky();
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b1 || pull_ack !== 1'b0) begin
            errors++;
            $display("FAIL stall_empty got stall=%b ack=%b want 1 0", stall, pull_ack);
        end
        tick();
        idle();
        #1;
        checks++;
        if (txstall !== 1'b1) begin
            errors++;
            $display("FAIL txstall_set got %b want 1", txstall);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        #1;
        checks++;
        if (txstall !== 1'b0) begin
            errors++;
            $display("FAIL txstall_clr got %b want 0", txstall);
        end
    endtask

    task automatic test_fill_overflow();
        logic [DW-1:0] w [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, w[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        #1;
        checks++;
        if (level !== 5'd4 || full !== 1'b1) begin
            errors++;
            $display("FAIL fill got lvl=%0d full=%b want 4 1", level, full);
        end
        drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        checks++;
        if (txover !== 1'b1 || level !== 5'd4) begin
            errors++;
            $display("FAIL overflow got ov=%b lvl=%0d want 1 4", txover, level);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if (pull_ack !== 1'b1 || pull_data !== w[i]) begin
                errors++;
                $display("FAIL drain%0d got ack=%b data=%h want 1 %h",
                         i, pull_ack, pull_data, w[i]);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (empty !== 1'b1 || level !== 5'd0) begin
            errors++;
            $display("FAIL drained got e=%b lvl=%0d want 1 0", empty, level);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_full_push_pull();
        logic [DW-1:0] w [4] = '{32'h22, 32'h33, 32'h44, 32'hAA};
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DW'(i * 'h11), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (pull_ack !== 1'b1 || pull_data !== 32'h11) begin
            errors++;
            $display("FAIL full_pp_data got ack=%b data=%h want 1 11", pull_ack, pull_data);
        end
        tick();
        idle();
        #1;
        checks++;
        if (level !== 5'd4 || txover !== 1'b0) begin
            errors++;
            $display("FAIL full_pp_lvl got lvl=%0d ov=%b want 4 0", level, txover);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if (pull_data !== w[i]) begin
                errors++;
                $display("FAIL full_pp_drain%0d got %h want %h", i, pull_data, w[i]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_empty_nb();
        x_reg = 32'hDEAD_BEEF;
        drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (pull_ack !== 1'b1 || pull_data !== 32'hDEAD_BEEF ||
            stall !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL nb_empty got ack=%b data=%h stall=%b lvl=%0d want 1 deadbeef 0 0",
                     pull_ack, pull_data, stall, level);
        end
        tick();
        idle();
        #1;
        checks++;
        if (level !== 5'd1 || pull_data !== 32'h77) begin
            errors++;
            $display("FAIL nb_push got lvl=%0d head=%h want 1 77", level, pull_data);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, DW'(i + 'h60), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        checks++;
        if (level !== 5'd0 || empty !== 1'b1 || txover !== 1'b1) begin
            errors++;
            $display("FAIL flush got lvl=%0d e=%b ov=%b want 0 1 1", level, empty, txover);
        end
        drive(1'b1, 32'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        checks++;
        if (pull_data !== 32'h12 || level !== 5'd1 || txover !== 1'b0) begin
            errors++;
            $display("FAIL post_flush got head=%h lvl=%0d ov=%b want 12 1 0",
                     pull_data, level, txover);
        end
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
    endtask

`ifdef PIO_TX_JOIN_EN
    task automatic test_join();
        fjoin_tx = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'(i + 'hC0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        #1;
        checks++;
        if (level !== 5'd8 || full !== 1'b1 || txover !== 1'b0) begin
            errors++;
            $display("FAIL join_fill got lvl=%0d f=%b ov=%b want 8 1 0", level, full, txover);
        end
        drive(1'b1, 32'hC8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        checks++;
        if (txover !== 1'b1 || pull_data !== 32'hC0) begin
            errors++;
            $display("FAIL join_over got ov=%b head=%h want 1 c0", txover, pull_data);
        end
        fjoin_tx = 1'b0;
        tick();
        #1;
        checks++;
        if (level !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL join_toggle got lvl=%0d e=%b want 0 1", level, empty);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bit e;
            logic [DW-1:0] exp_data;
            x_reg = $urandom;
            drive($urandom_range(0, 99) < 55, $urandom,
                  $urandom_range(0, 99) < 45, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0);
`ifdef PIO_TX_JOIN_EN
            if ($urandom_range(0, 49) == 0) fjoin_tx = ~fjoin_tx;
`endif
            #1;
            e = (q.size() == 0);
            exp_data = e ? x_reg : q[0];
            checks++;
            if (pull_ack !== (pull_req && (!e || !pull_block)) ||
                stall !== (pull_req && pull_block && e) ||
                pull_data !== exp_data) begin
                errors++;
                $display("FAIL rnd_pull n=%0d got ack=%b stall=%b data=%h want data=%h lvl=%0d",
                         n, pull_ack, stall, pull_data, exp_data, q.size());
            end
            checks++;
            if (level !== 5'(q.size()) || empty !== e ||
                full !== (q.size() == cap()) ||
                txover !== m_ov || txstall !== m_st) begin
                errors++;
                $display("FAIL rnd_state n=%0d got lvl=%0d f=%b ov=%b st=%b want %0d %b %b %b",
                         n, level, full, txover, txstall, q.size(),
                         q.size() == cap(), m_ov, m_st);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_stall_sticky();
        test_fill_overflow();
        test_full_push_pull();
        test_empty_nb();
        test_flush();
`ifdef PIO_TX_JOIN_EN
        test_join();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
